// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises ps2_clk, assembles 11-bit frames,
// validates them and queues good bytes in a small FIFO with 7-seg readout.
module ps2_keyboard #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;

  logic [2:0]         sync_q;
  logic [3:0]         cnt_q, cnt_d;
  logic [10:0]        frame_q, frame_d;
  logic               nd_q;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [DEPTH];

  logic        fall;
  logic [10:0] frame_full;
  logic        frame_ok;
  logic        full;
  logic        pop;
  logic        push_ok;

  // Falling edge seen between the two oldest synchroniser stages.
  assign fall       = sync_q[2] & ~sync_q[1];
  assign frame_full = {ps2_data, frame_q[9:0]};
  assign frame_ok   = fall && (cnt_q == 4'd10) && !frame_full[0] && frame_full[10]
                      && (^frame_full[9:1]);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign ready      = (count_q != '0);
  assign pop        = nd_q & ~nextdata_n & ready;
  assign push_ok    = frame_ok & (~full | pop);
  assign data       = mem_q[rd_ptr_q];
  assign overflow   = overflow_q;

  always_comb begin
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (fall) begin
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
      end else begin
        frame_d[cnt_q] = ps2_data;
        cnt_d          = cnt_q + 4'd1;
      end
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A pop in the same cycle frees the slot, so only a pop-less push on full is lost.
    if (frame_ok && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      sync_q     <= 3'b111;
      nd_q       <= 1'b1;
      cnt_q      <= 4'd0;
      frame_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], ps2_clk};
      nd_q       <= nextdata_n;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!clrn && push_ok) mem_q[wr_ptr_q] <= frame_full[8:1];
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign hex0 = ready ? seg7(data[3:0]) : 7'b1111111;
  assign hex1 = ready ? seg7(data[7:4]) : 7'b1111111;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: frames are driven bit by bit and the
// expected bytes are queued, then popped and checked against the FIFO output.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [6:0] hex0;
  logic [6:0] hex1;

  int         n_total = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  ps2_keyboard #(.FIFO_AW(3)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
    .hex0(hex0), .hex1(hex1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #15 ps2_clk = 1'b0;
    #30 ps2_clk = 1'b1;
    #15;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
    if (exp_q.size() < 8) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b1;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_blank(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_hex0"}, 32'(hex0), 32'h7F);
    chk({tag, "_hex1"}, 32'(hex1), 32'h7F);
  endtask

  // Pop n expected bytes, checking head data and hex decode before each pop.
  task automatic drain(input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
      chk("ready", 32'(ready), 32'd1);
      if (exp_q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
        return;
      end
      e = exp_q.pop_front();
      chk("data", 32'(data), 32'(e));
      chk("hex0", 32'(hex0), 32'(seg_tbl[e[3:0]]));
      chk("hex1", 32'(hex1), 32'(seg_tbl[e[7:4]]));
      nextdata_n = 1'b0;
      repeat (2) @(negedge clk);
      nextdata_n = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    do_reset();
    check_blank("reset");
    chk("reset_ovf", 32'(overflow), 32'd0);

    send_byte(8'h1C);
    chk("first_hex0", 32'(hex0), 32'b1000110);
    chk("first_hex1", 32'(hex1), 32'b1111001);
    drain(1);
    check_blank("after_pop");

    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain(3);
    check_blank("after_three");

    send_frame(8'h1B, 1'b1);
    repeat (4) @(negedge clk);
    chk("badpar_ready", 32'(ready), 32'd0);
    chk("badpar_ovf", 32'(overflow), 32'd0);

    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    chk("ovf_set", 32'(overflow), 32'(exp_ovf));
    drain(8);
    check_blank("after_ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    for (int i = 0; i < 5; i++) ps2_bit(1'(i == 4));
    do_reset();
    chk("midreset_ovf", 32'(overflow), 32'd0);
    chk("midreset_ready", 32'(ready), 32'd0);
    send_byte(8'h1B);
    drain(1);
    check_blank("after_1b");
    chk("final_ovf", 32'(overflow), 32'd0);
    chk("queue_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
